// File: rtl/otter_tmr_cntr.sv
// otter_tmr_cntr: programmable down-counting timer on the OTTER I/O bus.
// It decodes its own CSR and reload/count write ports from the bus. A
// power-of-two prescaler drives the count, and the timer raises a one-cycle
// interrupt pulse on terminal count.
// Ports:
//   CLK, RESET  - system clock; synchronous active-high reset
//   IOBUS_ADDR  - bus address from the MCU
//   IOBUS_OUT   - bus write data from the MCU
//   IOBUS_WR    - bus write strobe, one cycle per store
//   CNT_OUT     - live counter value
//   TC_DONE     - sticky flag: a one-shot run reached zero
//   TC_INTR     - interrupt pulse, one CLK wide
// CSR layout: [0] EN, [1] AR, [2] IE, [5:3] PS, [7:6] reserved.
module otter_tmr_cntr #(
    parameter logic [31:0] CSR_ADDR = 32'h1100D000,
    parameter logic [31:0] CNT_ADDR = 32'h1100D004,
    parameter int unsigned WIDTH    = 32
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic [31:0]      IOBUS_ADDR,
    input  logic [31:0]      IOBUS_OUT,
    input  logic             IOBUS_WR,
    output logic [WIDTH-1:0] CNT_OUT,
    output logic             TC_DONE,
    output logic             TC_INTR
);

    localparam int unsigned PSCL_W = 7;
    localparam int unsigned CSR_W  = 8;

    logic [CSR_W-1:0]  r_csr;
    logic [WIDTH-1:0]  r_reload;
    logic [WIDTH-1:0]  r_count;
    logic [PSCL_W-1:0] r_pscl;
    logic              r_done;
    logic              r_intr;

    logic              w_csr_wr;
    logic              w_cnt_wr;
    logic              w_en;
    logic              w_ar;
    logic              w_ie;
    logic [2:0]        w_ps;
    logic [PSCL_W-1:0] w_pscl_max;
    logic              w_tick;
    logic              w_term;
    logic              w_unused_rsvd;

    // Write decode: exact address match only.
    assign w_csr_wr = IOBUS_WR && (IOBUS_ADDR == CSR_ADDR);
    assign w_cnt_wr = IOBUS_WR && (IOBUS_ADDR == CNT_ADDR);

    assign w_en = r_csr[0];
    assign w_ar = r_csr[1];
    assign w_ie = r_csr[2];
    assign w_ps = r_csr[5:3];

    // Reserved CSR bits are stored as written but have no effect.
    assign w_unused_rsvd = ^r_csr[7:6];

    // The prescaler terminal value is 2^PS - 1. The 8-bit intermediate keeps PS=7 exact.
    assign w_pscl_max = PSCL_W'((8'd1 << w_ps) - 8'd1);
    assign w_tick     = w_en && (r_pscl == w_pscl_max);
    assign w_term     = w_tick && (r_count == WIDTH'(1));

    // Register update. Bus writes override any tick in the same cycle.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_csr    <= '0;
            r_reload <= '0;
            r_count  <= '0;
            r_pscl   <= '0;
            r_done   <= 1'b0;
            r_intr   <= 1'b0;
        end else begin
            r_intr <= 1'b0;
            if (w_cnt_wr) begin
                r_reload <= WIDTH'(IOBUS_OUT);
                r_count  <= WIDTH'(IOBUS_OUT);
                r_pscl   <= '0;
                r_done   <= 1'b0;
            end else if (w_csr_wr) begin
                r_csr  <= IOBUS_OUT[CSR_W-1:0];
                r_pscl <= '0;
                r_done <= 1'b0;
            end else if (w_en) begin
                r_pscl <= w_tick ? '0 : r_pscl + PSCL_W'(1);
                if (w_tick) begin
                    // A count of zero never wraps, so only a count of one is a terminal event.
                    if (r_count > WIDTH'(1)) begin
                        r_count <= r_count - WIDTH'(1);
                    end else if (w_term) begin
                        if (w_ar) begin
                            r_count <= r_reload;
                        end else begin
                            r_count <= '0;
                            r_done  <= 1'b1;
                        end
                        r_intr <= w_ie;
                    end
                end
            end else begin
                r_pscl <= '0;
            end
        end
    end

    assign CNT_OUT = r_count;
    assign TC_DONE = r_done;
    assign TC_INTR = r_intr;

endmodule

// File: tb/tb_otter_tmr_cntr.sv
// Self-checking bench for otter_tmr_cntr. Expected values come from closed-form
// arithmetic over the number of prescaled ticks since enable.
module tb_otter_tmr_cntr;

    localparam logic [31:0] CSR_A = 32'h1100D000;
    localparam logic [31:0] CNT_A = 32'h1100D004;
    localparam logic [31:0] BAD_A = 32'h1100D008;

    logic        clk;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        wr;
    logic [31:0] cnt_out;
    logic        tc_done;
    logic        tc_intr;

    int n_checks;
    int n_fail;
    int e_cnt;
    int e_done;
    int e_intr;

    otter_tmr_cntr #(
        .CSR_ADDR(CSR_A),
        .CNT_ADDR(CNT_A),
        .WIDTH   (32)
    ) dut (
        .CLK       (clk),
        .RESET     (rst),
        .IOBUS_ADDR(addr),
        .IOBUS_OUT (wdata),
        .IOBUS_WR  (wr),
        .CNT_OUT   (cnt_out),
        .TC_DONE   (tc_done),
        .TC_INTR   (tc_intr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        step();
        wr    = 1'b0;
        addr  = '0;
        wdata = '0;
    endtask

    // Expected state t edges after the enabling CSR write.
    // Start count c, auto-reload ar (reload == c), IE ie, prescale ps.
    // Ticks so far = floor(t / 2^ps).
    task automatic exp_model(input int c, input int ar, input int ie, input int ps,
                             input int t, output int o_cnt, output int o_done,
                             output int o_intr);
        int p;
        int n;
        p = 1 << ps;
        n = t / p;
        if (ar == 0) begin
            o_cnt  = (n >= c) ? 0 : c - n;
            o_done = (n >= c) ? 1 : 0;
            o_intr = (ie != 0 && t == c * p) ? 1 : 0;
        end else begin
            o_cnt  = c - (n % c);
            o_done = 0;
            o_intr = (ie != 0 && t > 0 && (t % p) == 0 && (n % c) == 0) ? 1 : 0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        addr = CSR_A;
        wdata = 32'hFF;
        wr = 1'b1;
        step();
        step();
        n_checks += 3;
        if (cnt_out !== 32'd0) begin n_fail++; $display("FAIL reset_cnt got %0h exp 0", cnt_out); end
        if (tc_done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %0b exp 0", tc_done); end
        if (tc_intr !== 1'b0) begin n_fail++; $display("FAIL reset_intr got %0b exp 0", tc_intr); end
        rst = 1'b0;
        wr = 1'b0;
        addr = '0;
        wdata = '0;
        // If the CSR had taken 0xFF, the counter would run.
        bus_wr(CNT_A, 32'd5);
        for (int i = 0; i < 4; i++) step();
        n_checks++;
        if (cnt_out !== 32'd5) begin n_fail++; $display("FAIL reset_csr_held got %0d exp 5", cnt_out); end
    endtask

    task automatic test_oneshot();
        bus_wr(CNT_A, 32'd5);
        bus_wr(CSR_A, 32'h05);
        for (int t = 0; t < 10; t++) begin
            exp_model(5, 0, 1, 0, t, e_cnt, e_done, e_intr);
            n_checks += 3;
            if (cnt_out !== 32'(e_cnt)) begin n_fail++; $display("FAIL oneshot_cnt t=%0d got %0d exp %0d", t, cnt_out, e_cnt); end
            if (tc_done !== 1'(e_done)) begin n_fail++; $display("FAIL oneshot_done t=%0d got %0b exp %0d", t, tc_done, e_done); end
            if (tc_intr !== 1'(e_intr)) begin n_fail++; $display("FAIL oneshot_intr t=%0d got %0b exp %0d", t, tc_intr, e_intr); end
            step();
        end
    endtask

    task automatic test_autoreload();
        bus_wr(CSR_A, 32'h00);
        bus_wr(CNT_A, 32'd3);
        bus_wr(CSR_A, 32'h17);
        for (int t = 0; t < 40; t++) begin
            exp_model(3, 1, 1, 2, t, e_cnt, e_done, e_intr);
            n_checks += 3;
            if (cnt_out !== 32'(e_cnt)) begin n_fail++; $display("FAIL autoreload_cnt t=%0d got %0d exp %0d", t, cnt_out, e_cnt); end
            if (tc_done !== 1'(e_done)) begin n_fail++; $display("FAIL autoreload_done t=%0d got %0b exp %0d", t, tc_done, e_done); end
            if (tc_intr !== 1'(e_intr)) begin n_fail++; $display("FAIL autoreload_intr t=%0d got %0b exp %0d", t, tc_intr, e_intr); end
            step();
        end
    endtask

    task automatic test_ie_masked();
        bus_wr(CSR_A, 32'h00);
        bus_wr(CNT_A, 32'd2);
        bus_wr(CSR_A, 32'h01);
        for (int t = 0; t < 6; t++) begin
            exp_model(2, 0, 0, 0, t, e_cnt, e_done, e_intr);
            n_checks += 3;
            if (cnt_out !== 32'(e_cnt)) begin n_fail++; $display("FAIL iemask_cnt t=%0d got %0d exp %0d", t, cnt_out, e_cnt); end
            if (tc_done !== 1'(e_done)) begin n_fail++; $display("FAIL iemask_done t=%0d got %0b exp %0d", t, tc_done, e_done); end
            if (tc_intr !== 1'b0) begin n_fail++; $display("FAIL iemask_intr t=%0d got %0b exp 0", t, tc_intr); end
            step();
        end
    endtask

    task automatic test_collision();
        bus_wr(CSR_A, 32'h00);
        bus_wr(CNT_A, 32'd4);
        bus_wr(CSR_A, 32'h05);
        for (int t = 0; t < 3; t++) step();
        n_checks++;
        if (cnt_out !== 32'd1) begin n_fail++; $display("FAIL collide_pre got %0d exp 1", cnt_out); end
        // The next edge would be the terminal tick; the CNT write lands on it.
        bus_wr(CNT_A, 32'd9);
        n_checks += 3;
        if (cnt_out !== 32'd9) begin n_fail++; $display("FAIL collide_cnt got %0d exp 9", cnt_out); end
        if (tc_intr !== 1'b0) begin n_fail++; $display("FAIL collide_intr got %0b exp 0", tc_intr); end
        if (tc_done !== 1'b0) begin n_fail++; $display("FAIL collide_done got %0b exp 0", tc_done); end
        step();
        n_checks += 2;
        if (cnt_out !== 32'd8) begin n_fail++; $display("FAIL collide_next got %0d exp 8", cnt_out); end
        if (tc_intr !== 1'b0) begin n_fail++; $display("FAIL collide_next_intr got %0b exp 0", tc_intr); end
    endtask

    task automatic test_decode_pause();
        bus_wr(CSR_A, 32'h00);
        bus_wr(CNT_A, 32'd7);
        bus_wr(BAD_A, 32'h07);
        // Matching address without the strobe must be ignored too.
        addr = CSR_A;
        wdata = 32'h07;
        wr = 1'b0;
        step();
        addr = '0;
        wdata = '0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (cnt_out !== 32'd7) begin n_fail++; $display("FAIL decode_cnt i=%0d got %0d exp 7", i, cnt_out); end
            step();
        end
        // Enable with EN, IE and PS=1.
        bus_wr(CSR_A, 32'h0D);
        for (int t = 0; t < 5; t++) begin
            exp_model(7, 0, 1, 1, t, e_cnt, e_done, e_intr);
            n_checks++;
            if (cnt_out !== 32'(e_cnt)) begin n_fail++; $display("FAIL pause_run_cnt t=%0d got %0d exp %0d", t, cnt_out, e_cnt); end
            if (t < 4) step();
        end
        // The count is frozen at its value after four edges (7 - 2 = 5).
        bus_wr(CSR_A, 32'h0C);
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (cnt_out !== 32'd5) begin n_fail++; $display("FAIL pause_hold i=%0d got %0d exp 5", i, cnt_out); end
            step();
        end
        bus_wr(CSR_A, 32'h0D);
        for (int t = 0; t < 13; t++) begin
            exp_model(5, 0, 1, 1, t, e_cnt, e_done, e_intr);
            n_checks += 3;
            if (cnt_out !== 32'(e_cnt)) begin n_fail++; $display("FAIL resume_cnt t=%0d got %0d exp %0d", t, cnt_out, e_cnt); end
            if (tc_done !== 1'(e_done)) begin n_fail++; $display("FAIL resume_done t=%0d got %0b exp %0d", t, tc_done, e_done); end
            if (tc_intr !== 1'(e_intr)) begin n_fail++; $display("FAIL resume_intr t=%0d got %0b exp %0d", t, tc_intr, e_intr); end
            step();
        end
    endtask

    task automatic test_random();
        int r;
        int ps;
        int ar;
        int ie;
        int rsv;
        int len;
        for (int it = 0; it < 8; it++) begin
            r   = int'($urandom_range(1, 5));
            ps  = int'($urandom_range(0, 3));
            ar  = int'($urandom_range(0, 1));
            ie  = int'($urandom_range(0, 1));
            rsv = int'($urandom_range(0, 3));
            len = r * (1 << ps) * 2 + 3;
            bus_wr(CSR_A, 32'h00);
            bus_wr(CNT_A, 32'(r));
            bus_wr(CSR_A, 32'((rsv << 6) | (ps << 3) | (ie << 2) | (ar << 1) | 1));
            for (int t = 0; t < len; t++) begin
                exp_model(r, ar, ie, ps, t, e_cnt, e_done, e_intr);
                n_checks += 3;
                if (cnt_out !== 32'(e_cnt)) begin n_fail++; $display("FAIL rand_cnt it=%0d t=%0d got %0d exp %0d", it, t, cnt_out, e_cnt); end
                if (tc_done !== 1'(e_done)) begin n_fail++; $display("FAIL rand_done it=%0d t=%0d got %0b exp %0d", it, t, tc_done, e_done); end
                if (tc_intr !== 1'(e_intr)) begin n_fail++; $display("FAIL rand_intr it=%0d t=%0d got %0b exp %0d", it, t, tc_intr, e_intr); end
                step();
            end
        end
    endtask

    task automatic test_reset_midcount();
        bus_wr(CSR_A, 32'h00);
        bus_wr(CNT_A, 32'd20);
        bus_wr(CSR_A, 32'h05);
        step();
        step();
        rst = 1'b1;
        addr = CNT_A;
        wdata = 32'd9;
        wr = 1'b1;
        step();
        rst = 1'b0;
        wr = 1'b0;
        addr = '0;
        wdata = '0;
        n_checks += 3;
        if (cnt_out !== 32'd0) begin n_fail++; $display("FAIL midreset_cnt got %0d exp 0", cnt_out); end
        if (tc_done !== 1'b0) begin n_fail++; $display("FAIL midreset_done got %0b exp 0", tc_done); end
        if (tc_intr !== 1'b0) begin n_fail++; $display("FAIL midreset_intr got %0b exp 0", tc_intr); end
        bus_wr(CNT_A, 32'd3);
        for (int i = 0; i < 3; i++) step();
        n_checks++;
        if (cnt_out !== 32'd3) begin n_fail++; $display("FAIL midreset_csr got %0d exp 3", cnt_out); end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        addr     = '0;
        wdata    = '0;
        wr       = 1'b0;
        test_reset();
        test_oneshot();
        test_autoreload();
        test_ie_masked();
        test_collision();
        test_decode_pause();
        test_random();
        test_reset_midcount();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
